// File: rtl/shift_stage_pkg.sv
// Shared constants and types for the RV32I shift execute stage.
// Optional perf counter in shift_exec_stage is enabled by SHIFT_STAGE_PERF_EN.
package shift_stage_pkg;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRX = 3'b101;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SLL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } buf_entry_t;

endpackage

// File: rtl/prim_shifter_32bit.sv
// Purely combinational 32-bit barrel shifter (SRL / SLL / SRA).
module prim_shifter_32bit
    import shift_stage_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    input  shift_mode_e i_mode,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data >> i_shamt;
        case (i_mode)
            SH_SLL:  o_data = i_data << i_shamt;
            SH_SRA:  o_data = $unsigned($signed(i_data) >>> i_shamt);
            default: o_data = i_data >> i_shamt;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// RV32I shift execute stage with a 2-entry in-order output buffer.
// Define SHIFT_STAGE_PERF_EN to build the completed-op counter on o_op_count.
module shift_exec_stage
    import shift_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic        i_use_imm,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_rd,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd,
    output logic        o_illegal,
    output logic [31:0] o_op_count
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("shift_exec_stage supports DEPTH == 2 only");
    end

    buf_state_e  r_state;
    logic        r_valid;
    logic        r_ready;
    buf_entry_t  r_ent0;
    buf_entry_t  r_ent1;

    logic [4:0]  w_shamt;
    shift_mode_e w_mode;
    logic        w_illegal;
    logic [31:0] w_shout;
    buf_entry_t  w_new;
    logic        w_acc;
    logic        w_xfer;
    logic        w_unused;

    // Only shamt[4:0] matters in RV32; upper operand bits are dropped here.
    assign w_shamt  = i_use_imm ? i_imm[4:0] : i_rs2[4:0];
    assign w_unused = ^{i_rs2[31:5], i_imm[31:5]};

    always_comb begin
        w_mode    = SH_SRL;
        w_illegal = 1'b0;
        case (i_funct3)
            FUNCT3_SLL: w_mode = SH_SLL;
            FUNCT3_SRX: w_mode = i_funct7_5 ? SH_SRA : SH_SRL;
            default:    w_illegal = 1'b1;
        endcase
    end

    prim_shifter_32bit u_shifter (
        .i_data  (i_rs1),
        .i_shamt (w_shamt),
        .i_mode  (w_mode),
        .o_data  (w_shout)
    );

    assign w_new.result  = w_illegal ? 32'd0 : w_shout;
    assign w_new.rd      = i_rd;
    assign w_new.illegal = w_illegal;

    assign w_acc  = i_valid & r_ready & ~i_flush;
    assign w_xfer = r_valid & i_ready;

    // o_valid/o_ready are registered alongside the state so neither depends
    // combinationally on i_ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else if (i_flush) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_ent0  <= w_new;
                        r_state <= ST_ONE;
                        r_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_xfer) begin
                        r_ent0 <= w_new;
                    end else if (w_acc) begin
                        r_ent1  <= w_new;
                        r_state <= ST_TWO;
                        r_ready <= 1'b0;
                    end else if (w_xfer) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_xfer) begin
                        r_ent0  <= r_ent1;
                        r_state <= ST_ONE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = r_valid;
    assign o_result  = r_ent0.result;
    assign o_rd      = r_ent0.rd;
    assign o_illegal = r_ent0.illegal;

`ifdef SHIFT_STAGE_PERF_EN
    logic [31:0] r_op_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_count <= 32'd0;
        end else if (w_xfer && !i_flush) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    assign o_op_count = r_op_count;
`else
    assign o_op_count = 32'd0;
`endif

endmodule
